// File: rtl/param_multicycle_cpu_if.sv
// Variable-latency req/ack memory port between the multicycle core (master)
// and instruction/data memory or bus fabric (slave).
interface param_multicycle_cpu_if #(
    parameter int ADDR_W = 8
) ();
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              mem_ack;
    logic [15:0]       mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/param_multicycle_cpu.sv
// Multicycle 16-bit core: eight registers (r5=sp, r6=lr, r7=pc), ALU with NZC
// flags, and a four-state control FSM driving a variable-latency memory port.
module param_multicycle_cpu #(
    parameter int          ADDR_W    = 8,
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [7:0]  STACK_TOP = 8'hFF
) (
    input  logic                          clk_50MHz,
    input  logic                          reset_n,
    input  logic                          run,
    param_multicycle_cpu_if.master        mem,
    output logic                          done,
    output logic [2:0]                    flags,
    input  logic [2:0]                    dbg_sel,
    output logic [15:0]                   dbg_data
);
    typedef enum logic [1:0] {IDLE, FETCH, EXEC, MEM} state_t;
    typedef enum logic [2:0] {
        OP_MV, OP_MVT, OP_ADD, OP_SUB, OP_LD, OP_ST, OP_AND, OP_BR
    } op_t;

    state_t      state, state_nxt;
    logic [15:0] regs [8];
    logic [15:0] ir;
    logic        flag_c, flag_n, flag_z;

    op_t         op;
    logic [2:0]  rx, ry;
    logic [15:0] op2;
    logic [16:0] alu_full;
    logic [15:0] br_target;
    logic        br_taken;
    logic        xfer_done;
    logic        is_mem_op;

    assign op        = op_t'(ir[15:13]);
    assign rx        = ir[11:9];
    assign ry        = ir[2:0];
    assign op2       = ir[12] ? {7'b0, ir[8:0]} : regs[ry];
    assign is_mem_op = (op == OP_LD) || (op == OP_ST);
    assign xfer_done = mem.mem_req && mem.mem_ack;
    // pc has already been incremented by the time EXEC computes the target.
    assign br_target = regs[7] + {{7{ir[8]}}, ir[8:0]};
    assign flags     = {flag_c, flag_n, flag_z};
    assign dbg_data  = regs[dbg_sel];

    // Subtraction as rX + ~Op2 + 1 so bit 16 is the "no borrow" carry.
    always_comb begin
        alu_full = '0;
        case (op)
            OP_ADD:  alu_full = {1'b0, regs[rx]} + {1'b0, op2};
            OP_SUB:  alu_full = {1'b0, regs[rx]} + {1'b0, ~op2} + 17'd1;
            OP_AND:  alu_full = {1'b0, regs[rx] & op2};
            default: alu_full = '0;
        endcase
    end

    always_comb begin
        case (rx)
            3'd1:    br_taken = flag_z;
            3'd2:    br_taken = !flag_z;
            3'd3:    br_taken = !flag_c;
            3'd4:    br_taken = flag_c;
            3'd5:    br_taken = !flag_n;
            3'd6:    br_taken = flag_n;
            default: br_taken = 1'b1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_50MHz or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // NOTE: defaulting state_nxt before the case keeps this purely
    // combinational; a missing assignment on any path would infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (run) state_nxt = FETCH;
            FETCH:   if (xfer_done) state_nxt = EXEC;
            EXEC:    state_nxt = is_mem_op ? MEM : (run ? FETCH : IDLE);
            MEM:     if (xfer_done) state_nxt = run ? FETCH : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request qualifiers depend only on state, IR and registers, none of which
    // change while a transfer waits, so they stay stable until ack.
    always_comb begin
        mem.mem_req   = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = regs[7][ADDR_W-1:0];
        mem.mem_wdata = regs[rx];
        done          = 1'b0;
        case (state)
            FETCH: mem.mem_req = 1'b1;
            EXEC:  done = !is_mem_op;
            MEM: begin
                mem.mem_req  = 1'b1;
                mem.mem_we   = (op == OP_ST);
                mem.mem_addr = regs[ry][ADDR_W-1:0];
                done         = mem.mem_ack;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_50MHz or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the register file is small and architecturally visible
            // (sp and pc have defined reset values), so it is fully reset
            // rather than treated as an uninitialised RAM.
            for (int i = 0; i < 8; i++) regs[i] <= '0;
            regs[5] <= {8'h00, STACK_TOP};
            regs[7] <= RESET_PC;
            ir      <= '0;
            flag_c  <= 1'b0;
            flag_n  <= 1'b0;
            flag_z  <= 1'b0;
        end else begin
            case (state)
                FETCH: if (xfer_done) begin
                    ir      <= mem.mem_rdata;
                    regs[7] <= regs[7] + 16'd1;
                end
                EXEC: case (op)
                    OP_MV:  regs[rx] <= op2;
                    OP_MVT: regs[rx] <= {ir[7:0], 8'h00};
                    OP_ADD, OP_SUB, OP_AND: begin
                        regs[rx] <= alu_full[15:0];
                        flag_c   <= alu_full[16];
                        flag_n   <= alu_full[15];
                        flag_z   <= (alu_full[15:0] == 16'h0000);
                    end
                    OP_BR: begin
                        if (rx == 3'd7) regs[6] <= regs[7];
                        if (br_taken)   regs[7] <= br_target;
                    end
                    default: ;
                endcase
                MEM: if (xfer_done && op == OP_LD) regs[rx] <= mem.mem_rdata;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_param_multicycle_cpu.sv
// Self-checking bench: vector table, directed multicycle sequences and a
// random program run against an instruction-level reference interpreter.
module tb_param_multicycle_cpu;
    localparam int          ADDR_W    = 8;
    localparam logic [15:0] RESET_PC  = 16'h0000;
    localparam logic [7:0]  STACK_TOP = 8'hFF;
    localparam int          NV        = 13;
    localparam int          NRAND     = 200;

    logic        clk      = 1'b0;
    logic        reset_n  = 1'b0;
    logic        run      = 1'b0;
    logic        done;
    logic [2:0]  flags;
    logic [2:0]  dbg_sel  = '0;
    logic [15:0] dbg_data;

    param_multicycle_cpu_if #(.ADDR_W(ADDR_W)) mif ();

    param_multicycle_cpu #(
        .ADDR_W(ADDR_W), .RESET_PC(RESET_PC), .STACK_TOP(STACK_TOP)
    ) dut (
        .clk_50MHz(clk), .reset_n(reset_n), .run(run), .mem(mif),
        .done(done), .flags(flags), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    always #10 clk = ~clk;

    // Memory model with programmable wait states and a preload port.
    bit   [15:0] mem [256];
    int          wait_cnt   = 0;
    int          cur_wait   = 0;
    int          fixed_wait = 0;
    bit          rand_wait  = 1'b0;
    logic        pl_en      = 1'b0;
    logic [7:0]  pl_addr    = '0;
    logic [15:0] pl_data    = '0;

    assign mif.mem_ack   = mif.mem_req && (wait_cnt >= cur_wait);
    assign mif.mem_rdata = mem[mif.mem_addr];

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        if (mif.mem_req && mif.mem_ack) begin
            if (mif.mem_we) mem[mif.mem_addr] <= mif.mem_wdata;
            wait_cnt <= 0;
            cur_wait <= rand_wait ? int'($urandom_range(0, 2)) : fixed_wait;
        end else if (mif.mem_req) begin
            wait_cnt <= wait_cnt + 1;
        end else begin
            wait_cnt <= 0;
            cur_wait <= rand_wait ? int'($urandom_range(0, 2)) : fixed_wait;
        end
    end

    // Bus monitors.
    int          cyc = 0, done_count = 0, req_cycles = 0, we_cycles = 0;
    int          wr_count = 0, unstable = 0;
    logic [7:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        pend = 1'b0, p_we = 1'b0;
    logic [7:0]  p_addr = '0;
    logic [15:0] p_wdata = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (done) done_count <= done_count + 1;
        if (mif.mem_req) req_cycles <= req_cycles + 1;
        if (mif.mem_req && mif.mem_we) we_cycles <= we_cycles + 1;
        if (mif.mem_req && mif.mem_ack && mif.mem_we) begin
            wr_count <= wr_count + 1;
            wr_addr  <= mif.mem_addr;
            wr_data  <= mif.mem_wdata;
        end
        if (pend && mif.mem_req && (mif.mem_addr != p_addr || mif.mem_we != p_we ||
            (p_we && mif.mem_wdata != p_wdata)))
            unstable <= unstable + 1;
        pend    <= mif.mem_req && !mif.mem_ack;
        p_addr  <= mif.mem_addr;
        p_we    <= mif.mem_we;
        p_wdata <= mif.mem_wdata;
    end

    int checks = 0, failures = 0;
    int last_done_cyc = 0, prev_done_cyc = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] enc(input logic [2:0] op, input logic imm,
                                        input logic [2:0] rx, input logic [8:0] f9);
        return {op, imm, rx, f9};
    endfunction

    task automatic rd(input logic [2:0] r, output logic [15:0] v);
        dbg_sel = r;
        #1;
        v = dbg_data;
    endtask

    task automatic load(input logic [7:0] a, input logic [15:0] d);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        @(posedge clk);
        #1;
        pl_en = 1'b0;
    endtask

    task automatic hold_reset(input int w);
        reset_n    = 1'b0;
        run        = 1'b0;
        rand_wait  = 1'b0;
        fixed_wait = w;
        @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Returns #1 after the retiring edge, inside the following cycle.
    task automatic wait_done(input string name, input int budget, output bit ok);
        bit got = 1'b0;
        for (int n = 0; n < budget && !got; n++) begin
            @(negedge clk);
            got = (done === 1'b1);
        end
        check({name, "_done_seen"}, 16'(got), 16'h0001);
        ok = got;
        if (!got) return;
        prev_done_cyc = last_done_cyc;
        last_done_cyc = cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string name, input int budget, input logic [7:0] addr);
        bit got = 1'b0;
        for (int n = 0; n < budget && !got; n++) begin
            @(negedge clk);
            got = (mif.mem_req === 1'b1) && (mif.mem_addr === addr);
        end
        check(name, 16'(got), 16'h0001);
    endtask

    // Instruction-level reference model.
    logic [15:0] m_r [8];
    logic [15:0] m_mem [256];
    logic        m_c, m_n, m_z;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_r[i] = 16'h0000;
        m_r[5] = {8'h00, STACK_TOP};
        m_r[7] = RESET_PC;
        {m_c, m_n, m_z} = 3'b000;
    endtask

    task automatic model_step();
        logic [15:0] ir, op2, res;
        logic [2:0]  x, y;
        int          a, b, s, off;
        bit          taken;
        ir     = m_mem[m_r[7][7:0]];
        m_r[7] = m_r[7] + 16'd1;
        x      = ir[11:9];
        y      = ir[2:0];
        op2    = ir[12] ? {7'b0, ir[8:0]} : m_r[y];
        a      = int'(m_r[x]);
        b      = int'(op2);
        res    = 16'h0000;
        case (ir[15:13])
            3'd0: m_r[x] = op2;
            3'd1: m_r[x] = {ir[7:0], 8'h00};
            3'd2: begin s = a + b; res = s[15:0]; m_c = (s > 65535); end
            3'd3: begin s = a - b; res = s[15:0]; m_c = (a >= b); end
            3'd4: m_r[x] = m_mem[m_r[y][7:0]];
            3'd5: m_mem[m_r[y][7:0]] = m_r[x];
            3'd6: begin res = m_r[x] & op2; m_c = 1'b0; end
            default: begin
                case (x)
                    3'd1: taken = m_z;
                    3'd2: taken = !m_z;
                    3'd3: taken = !m_c;
                    3'd4: taken = m_c;
                    3'd5: taken = !m_n;
                    3'd6: taken = m_n;
                    default: taken = 1'b1;
                endcase
                off = ir[8] ? int'(ir[8:0]) - 512 : int'(ir[8:0]);
                s   = (int'(m_r[7]) + off) & 32'hFFFF;
                if (x == 3'd7) m_r[6] = m_r[7];
                if (taken) m_r[7] = s[15:0];
            end
        endcase
        if (ir[15:13] == 3'd2 || ir[15:13] == 3'd3 || ir[15:13] == 3'd6) begin
            m_r[x] = res;
            m_n    = res[15];
            m_z    = (res == 16'h0000);
        end
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] instr;
        logic [15:0] exp_val;
        logic [2:0]  exp_flags;
    } vec_t;
    vec_t vecs [NV];

    initial begin #1_000_000; $display("FAIL watchdog: time limit reached"); $fatal(1); end

    initial begin
        bit          ok;
        logic [15:0] v, e;
        int          d0, r0, w0, c0, u0, ld_gap, alu_gap, bad;

        vecs[0]  = '{16'h1234, 16'h0001, enc(3'd2, 1'b0, 3'd1, 9'd2),     16'h1235, 3'b000};
        vecs[1]  = '{16'hFFFF, 16'h0000, enc(3'd2, 1'b1, 3'd1, 9'd1),     16'h0000, 3'b101};
        vecs[2]  = '{16'h0000, 16'h0000, enc(3'd3, 1'b1, 3'd1, 9'd1),     16'hFFFF, 3'b010};
        vecs[3]  = '{16'h0005, 16'h0005, enc(3'd3, 1'b0, 3'd1, 9'd2),     16'h0000, 3'b101};
        vecs[4]  = '{16'h0003, 16'h0005, enc(3'd3, 1'b0, 3'd1, 9'd2),     16'hFFFE, 3'b010};
        vecs[5]  = '{16'hF0F0, 16'h8F00, enc(3'd6, 1'b0, 3'd1, 9'd2),     16'h8000, 3'b010};
        vecs[6]  = '{16'hFF00, 16'h0000, enc(3'd6, 1'b1, 3'd1, 9'h0FF),   16'h0000, 3'b001};
        vecs[7]  = '{16'h0000, 16'h0000, enc(3'd0, 1'b1, 3'd1, 9'h1FF),   16'h01FF, 3'b000};
        vecs[8]  = '{16'h0000, 16'h0000, enc(3'd1, 1'b0, 3'd1, 9'h0AB),   16'hAB00, 3'b000};
        vecs[9]  = '{16'h0000, 16'hCAFE, enc(3'd0, 1'b0, 3'd1, 9'd2),     16'hCAFE, 3'b000};
        vecs[10] = '{16'h8000, 16'h8000, enc(3'd2, 1'b0, 3'd1, 9'd2),     16'h0000, 3'b101};
        vecs[11] = '{16'h7FFF, 16'h0001, enc(3'd2, 1'b0, 3'd1, 9'd2),     16'h8000, 3'b010};
        vecs[12] = '{16'h8000, 16'h0001, enc(3'd3, 1'b0, 3'd1, 9'd2),     16'h7FFF, 3'b100};

        // Reset state.
        hold_reset(0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_req", 16'(mif.mem_req), 16'h0000);
        check("rst_done", 16'(done), 16'h0000);
        check("rst_flags", 16'(flags), 16'h0000);
        for (int i = 0; i < 8; i++) begin
            rd(3'(i), v);
            e = (i == 5) ? {8'h00, STACK_TOP} : ((i == 7) ? RESET_PC : 16'h0000);
            check($sformatf("rst_r%0d", i), v, e);
        end
        release_reset();
        repeat (3) @(negedge clk);
        check("idle_no_req_without_run", 16'(mif.mem_req), 16'h0000);

        // Vector table: r1 and r2 loaded via ld, then one ALU/move op on r1.
        for (int i = 0; i < NV; i++) begin
            hold_reset(0);
            load(8'h00, enc(3'd0, 1'b1, 3'd3, 9'h080));
            load(8'h01, enc(3'd4, 1'b0, 3'd1, 9'd3));
            load(8'h02, enc(3'd0, 1'b1, 3'd3, 9'h081));
            load(8'h03, enc(3'd4, 1'b0, 3'd2, 9'd3));
            load(8'h04, vecs[i].instr);
            load(8'h05, 16'h0000);
            load(8'h80, vecs[i].a);
            load(8'h81, vecs[i].b);
            release_reset();
            run = 1'b1;
            ld_gap = 0; alu_gap = 0;
            for (int k = 0; k < 5; k++) begin
                wait_done($sformatf("vec%0d_i%0d", i, k), 20, ok);
                if (k == 1) ld_gap = last_done_cyc - prev_done_cyc;
                if (k == 4) alu_gap = last_done_cyc - prev_done_cyc;
            end
            rd(3'd1, v);
            check($sformatf("vec%0d_r1", i), v, vecs[i].exp_val);
            check($sformatf("vec%0d_flags", i), 16'(flags), 16'(vecs[i].exp_flags));
            check($sformatf("vec%0d_ld_cycles", i), 16'(ld_gap), 16'd3);
            check($sformatf("vec%0d_alu_cycles", i), 16'(alu_gap), 16'd2);
            run = 1'b0;
        end

        // mvt + add building 0x1234 with zero-wait memory.
        hold_reset(0);
        load(8'h00, enc(3'd1, 1'b0, 3'd0, 9'h012));
        load(8'h01, enc(3'd2, 1'b1, 3'd0, 9'h034));
        release_reset();
        run = 1'b1;
        wait_done("mvt", 20, ok);
        wait_done("add", 20, ok);
        rd(3'd0, v); check("seqA_r0", v, 16'h1234);
        check("seqA_flags", 16'(flags), 16'h0000);
        rd(3'd7, v); check("seqA_pc", v, 16'h0002);
        check("seqA_cycles", 16'(last_done_cyc - prev_done_cyc), 16'd2);
        run = 1'b0;

        // Store with three wait states per transfer.
        hold_reset(3);
        load(8'h00, enc(3'd0, 1'b1, 3'd3, 9'h080));
        load(8'h01, enc(3'd4, 1'b0, 3'd0, 9'd3));
        load(8'h02, enc(3'd0, 1'b1, 3'd2, 9'h040));
        load(8'h03, enc(3'd5, 1'b0, 3'd0, 9'd2));
        load(8'h40, 16'h0000);
        load(8'h80, 16'hBEEF);
        release_reset();
        d0 = done_count; w0 = we_cycles; c0 = wr_count; u0 = unstable;
        run = 1'b1;
        for (int k = 0; k < 3; k++) wait_done("seqB_pre", 40, ok);
        run = 1'b0;
        wait_done("seqB_st", 40, ok);
        check("seqB_st_cycles", 16'(last_done_cyc - prev_done_cyc), 16'd9);
        repeat (5) @(negedge clk);
        check("seqB_req_high_cycles", 16'(we_cycles - w0), 16'd4);
        check("seqB_write_count", 16'(wr_count - c0), 16'd1);
        check("seqB_write_addr", 16'(wr_addr), 16'h0040);
        check("seqB_write_data", wr_data, 16'hBEEF);
        check("seqB_mem40", mem[8'h40], 16'hBEEF);
        check("seqB_done_pulses", 16'(done_count - d0), 16'd4);
        check("seqB_stable", 16'(unstable - u0), 16'd0);
        check("seqB_idle_req", 16'(mif.mem_req), 16'h0000);

        // bl and a not-taken beq.
        hold_reset(0);
        load(8'h00, enc(3'd7, 1'b0, 3'd0, 9'h00F));
        load(8'h10, enc(3'd7, 1'b0, 3'd7, 9'd5));
        load(8'h16, enc(3'd7, 1'b0, 3'd1, 9'h1FE));
        load(8'h17, 16'h0000);
        release_reset();
        run = 1'b1;
        wait_done("seqC_b", 20, ok);
        rd(3'd7, v); check("seqC_b_pc", v, 16'h0010);
        wait_done("seqC_bl", 20, ok);
        rd(3'd6, v); check("seqC_bl_lr", v, 16'h0011);
        rd(3'd7, v); check("seqC_bl_pc", v, 16'h0016);
        wait_done("seqC_beq", 20, ok);
        rd(3'd7, v); check("seqC_beq_pc", v, 16'h0017);
        rd(3'd6, v); check("seqC_beq_lr", v, 16'h0011);
        run = 1'b0;

        // run dropped during the data phase of a load.
        hold_reset(2);
        load(8'h00, enc(3'd0, 1'b1, 3'd3, 9'h080));
        load(8'h01, enc(3'd4, 1'b0, 3'd4, 9'd3));
        load(8'h02, enc(3'd0, 1'b1, 3'd1, 9'h001));
        load(8'h80, 16'h5A5A);
        release_reset();
        run = 1'b1;
        wait_done("seqD_mv", 20, ok);
        wait_req("seqD_mem_phase", 20, 8'h80);
        run = 1'b0;
        wait_done("seqD_ld", 20, ok);
        rd(3'd4, v); check("seqD_r4", v, 16'h5A5A);
        d0 = done_count; r0 = req_cycles;
        repeat (6) @(negedge clk);
        check("seqD_idle_req_cycles", 16'(req_cycles - r0), 16'd0);
        check("seqD_idle_done", 16'(done_count - d0), 16'd0);
        run = 1'b1;
        wait_req("seqD_resume_fetch", 10, 8'h02);
        wait_done("seqD_mv2", 20, ok);
        rd(3'd1, v); check("seqD_r1", v, 16'h0001);
        run = 1'b0;

        // Reset asserted while a fetch is waiting for ack.
        hold_reset(4);
        load(8'h00, enc(3'd0, 1'b1, 3'd5, 9'h033));
        load(8'h01, enc(3'd2, 1'b1, 3'd1, 9'h000));
        release_reset();
        run = 1'b1;
        wait_done("seqE_mv", 40, ok);
        wait_done("seqE_add", 40, ok);
        check("seqE_pre_flags", 16'(flags), 16'h0001);
        rd(3'd5, v); check("seqE_pre_sp", v, 16'h0033);
        @(negedge clk);
        check("seqE_fetch_pending", 16'({mif.mem_req, mif.mem_ack}), 16'h0002);
        reset_n = 1'b0;
        #1;
        check("seqE_req_drop", 16'(mif.mem_req), 16'h0000);
        check("seqE_flags", 16'(flags), 16'h0000);
        rd(3'd7, v); check("seqE_pc", v, RESET_PC);
        rd(3'd5, v); check("seqE_sp", v, {8'h00, STACK_TOP});
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        wait_req("seqE_refetch", 10, RESET_PC[7:0]);
        run = 1'b0;

        // Random program with random wait states against the reference model.
        hold_reset(0);
        rand_wait = 1'b1;
        for (int i = 0; i < 256; i++) begin
            v = 16'($urandom);
            m_mem[i] = v;
            load(8'(i), v);
        end
        model_reset();
        u0 = unstable;
        release_reset();
        run = 1'b1;
        for (int k = 0; k < NRAND; k++) begin
            if (k == NRAND - 1) run = 1'b0;
            wait_done($sformatf("rnd%0d", k), 20, ok);
            if (!ok) break;
            model_step();
            for (int i = 0; i < 8; i++) begin
                rd(3'(i), v);
                check($sformatf("rnd%0d_r%0d", k, i), v, m_r[i]);
            end
            check($sformatf("rnd%0d_flags", k), 16'(flags), 16'({m_c, m_n, m_z}));
        end
        repeat (4) @(negedge clk);
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] != m_mem[i]) bad++;
        check("rnd_mem_mismatch_words", 16'(bad), 16'd0);
        check("rnd_bus_stable", 16'(unstable - u0), 16'd0);
        check("rnd_idle_req", 16'(mif.mem_req), 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
